// File: rtl/bitfusion_pkg.sv
// Shared types for the bit-fusion precision sequencer: precision codes, FSM states
// and the precision-to-one-hot width decode used by the sign-lookup stage.
package bitfusion_pkg;

    typedef enum logic [1:0] {
        PREC_1B = 2'd0,
        PREC_2B = 2'd1,
        PREC_4B = 2'd2,
        PREC_8B = 2'd3
    } prec_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_RUN,
        SEQ_DRAIN,
        SEQ_FIN
    } seq_state_t;

    function automatic logic [3:0] prec_to_onehot(input prec_t prec);
        return 4'b0001 << prec;
    endfunction

endpackage

// File: rtl/prec_cfg_table.sv
// Per-layer configuration register file: input precision, weight precision and op count.
// Synchronous write, asynchronous read; contents are deliberately not reset.
module prec_cfg_table #(
    parameter int NUM_LAYERS = 16,
    parameter int CNT_W      = 16,
    parameter int LAYER_W    = $clog2(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [LAYER_W-1:0] wr_addr,
    input  logic [1:0]         wr_in_prec,
    input  logic [1:0]         wr_wt_prec,
    input  logic [CNT_W-1:0]   wr_count,
    input  logic [LAYER_W-1:0] rd_addr,
    output logic [1:0]         rd_in_prec,
    output logic [1:0]         rd_wt_prec,
    output logic [CNT_W-1:0]   rd_count
);

    logic [1:0]       in_prec_mem [NUM_LAYERS];
    logic [1:0]       wt_prec_mem [NUM_LAYERS];
    logic [CNT_W-1:0] count_mem   [NUM_LAYERS];

    // Addresses past the table depth are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < NUM_LAYERS)) begin
            in_prec_mem[wr_addr] <= wr_in_prec;
            wt_prec_mem[wr_addr] <= wr_wt_prec;
            count_mem[wr_addr]   <= wr_count;
        end
    end

    assign rd_in_prec = in_prec_mem[rd_addr];
    assign rd_wt_prec = wt_prec_mem[rd_addr];
    assign rd_count   = count_mem[rd_addr];

endmodule

// File: rtl/precision_sequencer.sv
// Walks the layer table, driving one-hot widths and op beats, draining the array between layers.
// Optional SEQ_SAME_PREC_NODRAIN_EN skips the drain when consecutive layers share precisions.
module precision_sequencer
    import bitfusion_pkg::*;
#(
    parameter int NUM_LAYERS   = 16,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4,
    localparam int LAYER_W     = $clog2(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_wr_en,
    input  logic [LAYER_W-1:0] cfg_wr_addr,
    input  logic [1:0]         cfg_wr_in_prec,
    input  logic [1:0]         cfg_wr_wt_prec,
    input  logic [CNT_W-1:0]   cfg_wr_count,
    input  logic [LAYER_W:0]   cfg_num_layers,
    input  logic               start,
    input  logic               op_ready,
    output logic               op_valid,
    output logic               op_last,
    output logic [3:0]         in_width,
    output logic [3:0]         weight_width,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               busy,
    output logic               done
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [LAYER_W:0]   MAX_LAYERS = (LAYER_W + 1)'(NUM_LAYERS);
    localparam logic [LAYER_W:0]   ONE_LAYER  = (LAYER_W + 1)'(1);

    seq_state_t         state, state_next;
    logic [LAYER_W:0]   num_layers;
    logic [LAYER_W:0]   clamped_layers;
    logic [CNT_W-1:0]   op_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [LAYER_W-1:0] rd_addr;
    logic [1:0]         rd_in_prec;
    logic [1:0]         rd_wt_prec;
    logic [CNT_W-1:0]   rd_count;
    logic               tbl_wr_en;
    logic               more_layers;
    logic               op_fire;
    logic               run_start;
    logic               load_layer;
    logic               start_drain;
    logic               adv_layer;

    assign tbl_wr_en      = cfg_wr_en && (state == SEQ_IDLE);
    assign clamped_layers = (cfg_num_layers > MAX_LAYERS) ? MAX_LAYERS : cfg_num_layers;
    assign more_layers    = ({1'b0, layer_idx} + ONE_LAYER) < num_layers;

`ifdef SEQ_SAME_PREC_NODRAIN_EN
    logic same_prec;

    // While running, the read port looks ahead at the next layer to decide on the drain skip.
    assign rd_addr   = (state == SEQ_RUN) ? layer_idx + LAYER_W'(1) : layer_idx;
    assign same_prec = (prec_to_onehot(prec_t'(rd_in_prec)) == in_width) &&
                       (prec_to_onehot(prec_t'(rd_wt_prec)) == weight_width);
`else
    assign rd_addr = layer_idx;
`endif

    prec_cfg_table #(
        .NUM_LAYERS (NUM_LAYERS),
        .CNT_W      (CNT_W),
        .LAYER_W    (LAYER_W)
    ) u_table (
        .clk        (clk),
        .wr_en      (tbl_wr_en),
        .wr_addr    (cfg_wr_addr),
        .wr_in_prec (cfg_wr_in_prec),
        .wr_wt_prec (cfg_wr_wt_prec),
        .wr_count   (cfg_wr_count),
        .rd_addr    (rd_addr),
        .rd_in_prec (rd_in_prec),
        .rd_wt_prec (rd_wt_prec),
        .rd_count   (rd_count)
    );

    assign op_valid = (state == SEQ_RUN);
    assign op_last  = op_valid && (op_cnt == CNT_W'(1));
    assign op_fire  = op_valid && op_ready;
    assign busy     = (state != SEQ_IDLE);
    assign done     = (state == SEQ_FIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        run_start   = 1'b0;
        load_layer  = 1'b0;
        start_drain = 1'b0;
        adv_layer   = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (start) begin
                    run_start  = 1'b1;
                    state_next = (clamped_layers == '0) ? SEQ_FIN : SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                load_layer = 1'b1;
                if (rd_count == '0) begin
                    state_next  = SEQ_DRAIN;
                    start_drain = 1'b1;
                end else begin
                    state_next = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (op_ready && (op_cnt == CNT_W'(1))) begin
                    state_next  = SEQ_DRAIN;
                    start_drain = 1'b1;
`ifdef SEQ_SAME_PREC_NODRAIN_EN
                    if (more_layers && same_prec) begin
                        state_next  = SEQ_LOAD;
                        start_drain = 1'b0;
                        adv_layer   = 1'b1;
                    end
`endif
                end
            end
            SEQ_DRAIN: begin
                if (drain_cnt == '0) begin
                    if (more_layers) begin
                        state_next = SEQ_LOAD;
                        adv_layer  = 1'b1;
                    end else begin
                        state_next = SEQ_FIN;
                    end
                end
            end
            SEQ_FIN:  state_next = SEQ_IDLE;
            default:  state_next = SEQ_IDLE;
        endcase
    end

    // Widths only move on the LOAD edge, so they stay constant across every beat of a layer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_idx    <= '0;
            num_layers   <= '0;
            in_width     <= 4'b1000;
            weight_width <= 4'b1000;
            op_cnt       <= '0;
            drain_cnt    <= '0;
        end else begin
            if (run_start) begin
                layer_idx  <= '0;
                num_layers <= clamped_layers;
            end
            if (load_layer) begin
                in_width     <= prec_to_onehot(prec_t'(rd_in_prec));
                weight_width <= prec_to_onehot(prec_t'(rd_wt_prec));
                op_cnt       <= rd_count;
            end else if (op_fire) begin
                op_cnt <= op_cnt - CNT_W'(1);
            end
            if (start_drain) begin
                drain_cnt <= DRAIN_LAST;
            end else if ((state == SEQ_DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
            if (adv_layer) begin
                layer_idx <= layer_idx + LAYER_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_precision_sequencer.sv
// Directed bench for precision_sequencer; expectations are hand-derived cycle counts and widths.
// Drain-gap expectation follows SEQ_SAME_PREC_NODRAIN_EN when the bench is built with it.
module tb_precision_sequencer;
    import bitfusion_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr_en;
    logic [3:0]  cfg_wr_addr;
    logic [1:0]  cfg_wr_in_prec;
    logic [1:0]  cfg_wr_wt_prec;
    logic [15:0] cfg_wr_count;
    logic [4:0]  cfg_num_layers;
    logic        start;
    logic        op_ready;
    logic        op_valid;
    logic        op_last;
    logic [3:0]  in_width;
    logic [3:0]  weight_width;
    logic [3:0]  layer_idx;
    logic        busy;
    logic        done;

    int check_count = 0;
    int pass_count  = 0;

    int         hs_n;
    int         done_n;
    int         viol;
    bit         timed_out;
    int         hs_cyc  [64];
    logic [3:0] hs_in   [64];
    logic [3:0] hs_wt   [64];
    logic       hs_last [64];
    logic [3:0] seen_in [16];
    logic [3:0] seen_wt [16];
    bit         ready_q [$];
    int         exp_gap;

    precision_sequencer #(
        .NUM_LAYERS   (16),
        .CNT_W        (16),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_in_prec (cfg_wr_in_prec),
        .cfg_wr_wt_prec (cfg_wr_wt_prec),
        .cfg_wr_count   (cfg_wr_count),
        .cfg_num_layers (cfg_num_layers),
        .start          (start),
        .op_ready       (op_ready),
        .op_valid       (op_valid),
        .op_last        (op_last),
        .in_width       (in_width),
        .weight_width   (weight_width),
        .layer_idx      (layer_idx),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [1:0] ip, input logic [1:0] wp,
                               input logic [15:0] cnt);
        cfg_wr_en      = 1'b1;
        cfg_wr_addr    = addr;
        cfg_wr_in_prec = ip;
        cfg_wr_wt_prec = wp;
        cfg_wr_count   = cnt;
        step();
        cfg_wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] n);
        cfg_num_layers = n;
        start          = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Serves op_ready (from ready_q, else 1), logs handshakes, returns one cycle after done.
    task automatic apply_stimulus(input int max_cycles);
        logic       prev_valid;
        logic       prev_ready;
        logic [3:0] prev_in;
        logic [3:0] prev_wt;
        hs_n = 0; done_n = 0; viol = 0; timed_out = 1'b1;
        prev_valid = 1'b0; prev_ready = 1'b0;
        prev_in = in_width; prev_wt = weight_width;
        for (int i = 0; i < max_cycles; i++) begin
            if (prev_valid && ((in_width != prev_in) || (weight_width != prev_wt))) viol++;
            if (prev_valid && !prev_ready && !op_valid) viol++;
            if (busy) begin
                seen_in[layer_idx] = in_width;
                seen_wt[layer_idx] = weight_width;
            end
            op_ready = 1'b0;
            if (op_valid) begin
                op_ready = (ready_q.size() > 0) ? ready_q.pop_front() : 1'b1;
                if (op_ready && hs_n < 64) begin
                    hs_cyc[hs_n]  = i;
                    hs_in[hs_n]   = in_width;
                    hs_wt[hs_n]   = weight_width;
                    hs_last[hs_n] = op_last;
                    hs_n++;
                end
            end
            if (done) done_n++;
            prev_valid = op_valid; prev_ready = op_ready;
            prev_in = in_width; prev_wt = weight_width;
            step();
            if (done_n > 0 && !done) begin
                timed_out = 1'b0;
                break;
            end
        end
        op_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_in_prec = '0;
        cfg_wr_wt_prec = '0; cfg_wr_count = '0; cfg_num_layers = '0; start = 1'b0; op_ready = 1'b0;
        step();
        step();
        check_output("rst_op_valid", op_valid, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_in_width", in_width, 4'b1000);
        check_output("rst_wt_width", weight_width, 4'b1000);
        check_output("rst_layer_idx", layer_idx, 4'd0);
        reset = 1'b0;
        step();

        // Reset mid-run: layer 1 with 5 ops still pending
        write_entry(4'd0, PREC_8B, PREC_8B, 16'd1);
        write_entry(4'd1, PREC_2B, PREC_2B, 16'd6);
        op_ready = 1'b1;
        start_run(5'd2);
        for (int i = 0; i < 50 && !(layer_idx == 4'd1 && op_valid); i++) step();
        check_output("t1_reach_layer1", (layer_idx == 4'd1) && op_valid, 1'b1);
        step();
        check_output("t1_still_valid", op_valid, 1'b1);
        check_output("t1_not_last", op_last, 1'b0);
        check_output("t1_width_2b", in_width, 4'b0010);
        #2 reset = 1'b1;
        #1;
        check_output("t1_async_valid", op_valid, 1'b0);
        check_output("t1_async_busy", busy, 1'b0);
        check_output("t1_async_in", in_width, 4'b1000);
        check_output("t1_async_wt", weight_width, 4'b1000);
        check_output("t1_async_idx", layer_idx, 4'd0);
        op_ready = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Two layers; entry 0 written in the same cycle as start
        write_entry(4'd1, PREC_2B, PREC_4B, 16'd2);
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0; cfg_wr_in_prec = PREC_8B;
        cfg_wr_wt_prec = PREC_8B; cfg_wr_count = 16'd3;
        start_run(5'd2);
        cfg_wr_en = 1'b0;
        check_output("t2_busy_after_start", busy, 1'b1);
        apply_stimulus(200);
        check_output("t2_timeout", timed_out, 1'b0);
        check_output("t2_beats", hs_n, 5);
        check_output("t2_b0_in", hs_in[0], 4'b1000);
        check_output("t2_b2_wt", hs_wt[2], 4'b1000);
        check_output("t2_b1_last", hs_last[1], 1'b0);
        check_output("t2_b2_last", hs_last[2], 1'b1);
        check_output("t2_drain_gap", hs_cyc[3] - hs_cyc[2] - 1, 5);
        check_output("t2_b3_in", hs_in[3], 4'b0010);
        check_output("t2_b3_wt", hs_wt[3], 4'b0100);
        check_output("t2_b4_last", hs_last[4], 1'b1);
        check_output("t2_done_pulses", done_n, 1);
        check_output("t2_width_rule", viol, 0);
        check_output("t2_busy_end", busy, 1'b0);
        check_output("t2_last_widths", {in_width, weight_width}, 8'b0010_0100);

        // Stalls: ready pattern 1,0,0,1 on a two-op layer
        write_entry(4'd0, PREC_4B, PREC_4B, 16'd2);
        ready_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        start_run(5'd1);
        apply_stimulus(100);
        check_output("t3_timeout", timed_out, 1'b0);
        check_output("t3_handshakes", hs_n, 2);
        check_output("t3_stall_span", hs_cyc[1] - hs_cyc[0], 3);
        check_output("t3_last_flags", {hs_last[0], hs_last[1]}, 2'b01);
        check_output("t3_held_valid", viol, 0);

        // Zero-op middle layer
        write_entry(4'd0, PREC_1B, PREC_1B, 16'd1);
        write_entry(4'd1, PREC_8B, PREC_2B, 16'd0);
        write_entry(4'd2, PREC_4B, PREC_1B, 16'd1);
        start_run(5'd3);
        apply_stimulus(200);
        check_output("t4_timeout", timed_out, 1'b0);
        check_output("t4_beats", hs_n, 2);
        check_output("t4_gap", hs_cyc[1] - hs_cyc[0] - 1, 10);
        check_output("t4_l1_widths", {seen_in[1], seen_wt[1]}, 8'b1000_0010);
        check_output("t4_final_widths", {in_width, weight_width}, 8'b0100_0001);

        // Zero layers, then start/write while busy
        start_run(5'd0);
        apply_stimulus(20);
        check_output("t5_zero_timeout", timed_out, 1'b0);
        check_output("t5_zero_beats", hs_n, 0);
        check_output("t5_zero_done", done_n, 1);
        write_entry(4'd0, PREC_8B, PREC_8B, 16'd2);
        start_run(5'd1);
        start = 1'b1; cfg_wr_en = 1'b1; cfg_wr_addr = 4'd0;
        cfg_wr_in_prec = PREC_1B; cfg_wr_wt_prec = PREC_1B; cfg_wr_count = 16'd7;
        step();
        start = 1'b0; cfg_wr_en = 1'b0;
        apply_stimulus(100);
        check_output("t5_busy_beats", hs_n, 2);
        step(); step();
        check_output("t5_no_restart", busy, 1'b0);
        start_run(5'd1);
        apply_stimulus(100);
        check_output("t5_write_ignored_n", hs_n, 2);
        check_output("t5_write_ignored_w", hs_in[0], 4'b1000);

        // num_layers above table depth clamps to 16
        for (int a = 0; a < 16; a++) write_entry(4'(a), PREC_8B, PREC_8B, 16'd1);
        start_run(5'd31);
        apply_stimulus(400);
        check_output("clamp_timeout", timed_out, 1'b0);
        check_output("clamp_beats", hs_n, 16);

        // Same-precision boundary: drain skipped only when the option is built in
`ifdef SEQ_SAME_PREC_NODRAIN_EN
        exp_gap = 1;
`else
        exp_gap = 5;
`endif
        write_entry(4'd0, PREC_4B, PREC_4B, 16'd2);
        write_entry(4'd1, PREC_4B, PREC_4B, 16'd2);
        start_run(5'd2);
        apply_stimulus(200);
        check_output("t6_beats", hs_n, 4);
        check_output("t6_gap", hs_cyc[2] - hs_cyc[1] - 1, exp_gap);
        check_output("t6_width_rule", viol, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
